// File: rtl/fir_coeff_loader_pkg.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader_pkg
// Shared types and constants for the FIR coefficient loader:
//   - state_t     : loader FSM states
//   - BANK_W/TAP_W/ADDR_W/COEFF_W/CNT_W : field widths
//   - make_addr() : packs {bank, tap} into the RAM address bus
// -----------------------------------------------------------------------------
package fir_coeff_loader_pkg;

    localparam int BANK_W  = 2;
    localparam int TAP_W   = 4;
    localparam int ADDR_W  = 6;
    localparam int COEFF_W = 16;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        FETCH = 3'd2,
        WRITE = 3'd3,
        GAP   = 3'd4,
        HOLD  = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Taps 10..15 of each bank are left as holes in the address map.
    function automatic logic [ADDR_W-1:0] make_addr(input logic [BANK_W-1:0] bank,
                                                    input logic [TAP_W-1:0]  tap);
        return {bank, tap};
    endfunction

endpackage

// File: rtl/fir_coeff_addr_gen.sv
// -----------------------------------------------------------------------------
// fir_coeff_addr_gen
// Bank/tap counter that walks the coefficient RAM address space bank by bank.
// Ports:
//   clk      in  clock
//   rst      in  synchronous reset, active-high
//   clear    in  return bank and tap to 0
//   advance  in  step to the next tap, rolling into the next bank at the end
//   bank     out current bank index
//   tap      out current tap index
//   last     out current position is the final coefficient of the final bank
// -----------------------------------------------------------------------------
module fir_coeff_addr_gen
    import fir_coeff_loader_pkg::*;
#(
    parameter int NUM_BANK      = 4,
    parameter int TAPS_PER_BANK = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [BANK_W-1:0] bank,
    output logic [TAP_W-1:0]  tap,
    output logic              last
);

    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANK - 1);
    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS_PER_BANK - 1);

    logic [BANK_W-1:0] bank_r;
    logic [TAP_W-1:0]  tap_r;

    // Bank/tap position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_r <= {BANK_W{1'b0}};
            tap_r  <= {TAP_W{1'b0}};
        end else if (clear) begin
            bank_r <= {BANK_W{1'b0}};
            tap_r  <= {TAP_W{1'b0}};
        end else if (advance) begin
            if (tap_r == TAP_LAST) begin
                tap_r  <= {TAP_W{1'b0}};
                bank_r <= bank_r + {{(BANK_W-1){1'b0}}, 1'b1};
            end else begin
                tap_r  <= tap_r + {{(TAP_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bank = bank_r;
    assign tap  = tap_r;
    assign last = (bank_r == BANK_LAST) && (tap_r == TAP_LAST);

endmodule

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
// Host-side initiator for the FIR coefficient-update port. Pulls coefficients
// from a valid/ready stream and writes all NUM_BANK x TAPS_PER_BANK of them
// into the filter RAM, framed by the update flag with setup/hold margins.
// Optional feature macro: COEFF_LOADER_CKSUM_EN (running checksum + compare).
// Ports:
//   iClk12M          in   clock (rising edge)
//   iRst             in   synchronous reset, active-high
//   iStart           in   start-load pulse, honoured only in IDLE
//   iAbort           in   abort the load in progress
//   iCoeffValid      in   source data valid
//   iCoeffData[15:0] in   coefficient (two's complement)
//   iCksumExp[15:0]  in   expected checksum (COEFF_LOADER_CKSUM_EN only)
//   oCksum[15:0]     out  running checksum    (COEFF_LOADER_CKSUM_EN only)
//   oCoeffReady      out  loader accepts a coefficient this cycle
//   oCoeffUpdateFlag out  filter update-mode request
//   oCsnRam          out  RAM chip select, active-low
//   oWrnRam          out  RAM write enable, active-low
//   oAddrRam[5:0]    out  {bank, tap}
//   oWtDtRam[15:0]   out  write data
//   oBusy            out  loader not idle
//   oDone            out  1-cycle pulse on successful completion
//   oErr             out  1-cycle pulse on abort or checksum mismatch
// -----------------------------------------------------------------------------
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int NUM_BANK      = 4,
    parameter int TAPS_PER_BANK = 10,
    parameter int SETUP_CYC     = 2,
    parameter int WR_GAP        = 1,
    parameter int HOLD_CYC      = 2
) (
    input  logic               iClk12M,
    input  logic               iRst,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic               iCoeffValid,
    input  logic [COEFF_W-1:0] iCoeffData,
`ifdef COEFF_LOADER_CKSUM_EN
    input  logic [COEFF_W-1:0] iCksumExp,
    output logic [COEFF_W-1:0] oCksum,
`endif
    output logic               oCoeffReady,
    output logic               oCoeffUpdateFlag,
    output logic               oCsnRam,
    output logic               oWrnRam,
    output logic [ADDR_W-1:0]  oAddrRam,
    output logic [COEFF_W-1:0] oWtDtRam,
    output logic               oBusy,
    output logic               oDone,
    output logic               oErr
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((WR_GAP > 0) ? (WR_GAP - 1) : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               clear_s;
    logic               advance_s;
    logic               abort_s;
    logic               xfer_s;
    logic [BANK_W-1:0]  bank_s;
    logic [TAP_W-1:0]   tap_s;
    logic               last_s;
    logic               cksum_bad_s;

    logic               ready_s;
    logic               flag_s;
    logic               wr_s;
    logic               busy_s;
    logic               done_s;
    logic               err_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [COEFF_W-1:0] data_s;

    fir_coeff_addr_gen #(
        .NUM_BANK      (NUM_BANK),
        .TAPS_PER_BANK (TAPS_PER_BANK)
    ) u_addr_gen (
        .clk     (iClk12M),
        .rst     (iRst),
        .clear   (clear_s),
        .advance (advance_s),
        .bank    (bank_s),
        .tap     (tap_s),
        .last    (last_s)
    );

    assign abort_s = (state_r != IDLE) && iAbort;
    assign xfer_s  = iCoeffValid && oCoeffReady;

    // FSM state register.
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Dwell counter for SETUP/GAP/HOLD; restarts on every state change.
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_next_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic plus address counter control; abort overrides everything.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        advance_s    = 1'b0;
        if (abort_s) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (iStart && !iAbort) begin
                        state_next_s = SETUP;
                        clear_s      = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        state_next_s = FETCH;
                    end else begin
                        state_next_s = SETUP;
                    end
                end
                FETCH: begin
                    if (xfer_s) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = FETCH;
                    end
                end
                WRITE: begin
                    // With no gap configured, the write cycle ends the slot itself.
                    if (WR_GAP > 0) begin
                        state_next_s = GAP;
                    end else begin
                        advance_s    = !last_s;
                        state_next_s = last_s ? HOLD : FETCH;
                    end
                end
                GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        advance_s    = !last_s;
                        state_next_s = last_s ? HOLD : FETCH;
                    end else begin
                        state_next_s = GAP;
                    end
                end
                HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = HOLD;
                    end
                end
                DONE: begin
                    state_next_s = IDLE;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

`ifdef COEFF_LOADER_CKSUM_EN
    logic [COEFF_W-1:0] cksum_r;

    // Modulo-2^16 sum of every coefficient put on the write bus.
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            cksum_r <= {COEFF_W{1'b0}};
        end else if (clear_s) begin
            cksum_r <= {COEFF_W{1'b0}};
        end else if (state_r == WRITE) begin
            cksum_r <= cksum_r + oWtDtRam;
        end
    end

    assign oCksum      = cksum_r;
    assign cksum_bad_s = (cksum_r != iCksumExp);
`else
    assign cksum_bad_s = 1'b0;
`endif

    // Output decode from the next state so registered pins line up with the state.
    always_comb begin
        ready_s = (state_next_s == FETCH);
        wr_s    = (state_next_s == WRITE);
        busy_s  = (state_next_s != IDLE);
        flag_s  = (state_next_s == SETUP) || (state_next_s == FETCH) ||
                  (state_next_s == WRITE) || (state_next_s == GAP)   ||
                  (state_next_s == HOLD);
        done_s  = (state_next_s == DONE) && !cksum_bad_s;
        err_s   = abort_s || ((state_next_s == DONE) && cksum_bad_s);
        // WRITE is only entered from FETCH on a transfer, so data is live here.
        if (wr_s) begin
            addr_s = make_addr(bank_s, tap_s);
            data_s = iCoeffData;
        end else begin
            addr_s = oAddrRam;
            data_s = oWtDtRam;
        end
    end

    // Output registers.
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            oCoeffReady      <= 1'b0;
            oCoeffUpdateFlag <= 1'b0;
            oCsnRam          <= 1'b1;
            oWrnRam          <= 1'b1;
            oAddrRam         <= {ADDR_W{1'b0}};
            oWtDtRam         <= {COEFF_W{1'b0}};
            oBusy            <= 1'b0;
            oDone            <= 1'b0;
            oErr             <= 1'b0;
        end else begin
            oCoeffReady      <= ready_s;
            oCoeffUpdateFlag <= flag_s;
            oCsnRam          <= !wr_s;
            oWrnRam          <= !wr_s;
            oAddrRam         <= addr_s;
            oWtDtRam         <= data_s;
            oBusy            <= busy_s;
            oDone            <= done_s;
            oErr             <= err_s;
        end
    end

endmodule
